// File: rtl/lsu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl_pkg
// Description : Shared constants and types for the load/store unit controller:
//               memory op codes, funct3 codes, fault codes, FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_ctrl_pkg;

  // Memory op codes (op[2] = 0 means write)
  localparam logic [2:0] c_op_lw   = 3'b110;
  localparam logic [2:0] c_op_idle = 3'b111;

  // RISC-V load funct3 codes
  localparam logic [2:0] c_f3_b  = 3'b000;
  localparam logic [2:0] c_f3_h  = 3'b001;
  localparam logic [2:0] c_f3_w  = 3'b010;
  localparam logic [2:0] c_f3_bu = 3'b100;
  localparam logic [2:0] c_f3_hu = 3'b101;

  // Response fault codes
  localparam logic [1:0] c_fault_ok         = 2'b00;
  localparam logic [1:0] c_fault_misaligned = 2'b01;
  localparam logic [1:0] c_fault_range      = 2'b10;
  localparam logic [1:0] c_fault_illegal    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RESP   = 2'd1,
    ST_SPLIT1 = 2'd2,
    ST_SPLIT2 = 2'd3
  } lsu_state_t;

  // Access size minus one, from the low two funct3 bits (0, 1 or 3 bytes)
  function automatic logic [1:0] size_m1(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_align
// Description : Shifts a 64-bit little-endian load window down by the byte
//               offset and sign/zero-extends according to funct3.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_align
  import lsu_ctrl_pkg::*;
(
  input  logic [63:0] window,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] w_low;

  // Only the low word of the shifted window can ever hold the loaded value
  assign w_low = 32'(window >> {offset, 3'b000});

  // Extension of the selected bytes
  always_comb begin
    data = w_low;
    case (funct3)
      c_f3_b:  data = {{24{w_low[7]}}, w_low[7:0]};
      c_f3_h:  data = {{16{w_low[15]}}, w_low[15:0]};
      c_f3_w:  data = w_low;
      c_f3_bu: data = {24'b0, w_low[7:0]};
      c_f3_hu: data = {16'b0, w_low[15:0]};
      default: data = w_low;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl
// Description : MEM-stage load/store initiator. One request at a time,
//               fault checking, word-crossing loads split into two reads.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 11,
  parameter int SPLIT_EN = 1
)
(
  input  logic              clk,
  input  logic              nrst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_fault,
  output logic              mem_stall,
  output logic [2:0]        mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t        r_state;
  logic [31:0]       r_lo_buf;
  logic [2:0]        r_funct3;
  logic [1:0]        r_offset;
  logic              r_we;
  logic [ADDR_W-3:0] r_word;

  logic [1:0]        w_size_m1;
  logic [ADDR_W:0]   w_end;
  logic              w_illegal;
  logic              w_range;
  logic              w_cross;
  logic              w_store_mis;
  logic              w_misalign;
  logic [1:0]        w_fault;
  logic              w_accept;
  logic              w_issue;
  logic [ADDR_W-3:0] w_word_next;
  logic [63:0]       w_window;
  logic [31:0]       w_aligned;

  assign req_ready = (r_state == ST_IDLE);
  assign w_accept  = req_valid & req_ready;

  // Request classification, evaluated in the acceptance cycle
  assign w_size_m1   = size_m1(req_funct3);
  assign w_illegal   = req_we ? (req_funct3 >= 3'b011)
                              : (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111);
  assign w_end       = {1'b0, req_addr[ADDR_W-1:0]} + {{(ADDR_W-1){1'b0}}, w_size_m1};
  assign w_range     = w_end[ADDR_W] | (|req_addr[31:ADDR_W]);
  // A load crosses a word boundary when its last byte lands in the next word
  assign w_cross     = !req_we && ((req_funct3[1:0] == 2'b01 && req_addr[1:0] == 2'd3) ||
                                   (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'd0));
  assign w_store_mis = req_we && ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                                  (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'd0));
  assign w_misalign  = w_store_mis | (w_cross & (SPLIT_EN == 0));

  // Fault priority: illegal over range over misaligned
  always_comb begin
    w_fault = c_fault_ok;
    if (w_illegal)       w_fault = c_fault_illegal;
    else if (w_range)    w_fault = c_fault_range;
    else if (w_misalign) w_fault = c_fault_misaligned;
  end

  assign w_issue     = w_accept && (w_fault == c_fault_ok);
  assign w_word_next = r_word + {{(ADDR_W-3){1'b0}}, 1'b1};

  // Memory port: the request is issued combinationally on acceptance, the
  // second half of a split load in SPLIT1; otherwise the port sits idle
  always_comb begin
    mem_stall = 1'b1;
    mem_op    = c_op_idle;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_issue) begin
      mem_stall = 1'b0;
      if (req_we) begin
        mem_op    = {1'b0, req_funct3[1:0]};
        mem_addr  = req_addr[ADDR_W-1:0];
        mem_wdata = req_wdata;
      end else begin
        mem_op   = c_op_lw;
        mem_addr = {req_addr[ADDR_W-1:2], 2'b00};
      end
    end else if (r_state == ST_SPLIT1) begin
      mem_stall = 1'b0;
      mem_op    = c_op_lw;
      mem_addr  = {w_word_next, 2'b00};
    end
  end

  // Load window: the single read word, or both halves of a split load
  assign w_window = (r_state == ST_SPLIT2) ? {mem_rdata, r_lo_buf} : {32'b0, mem_rdata};

  lsu_load_align u_align (
    .window (w_window),
    .offset (r_offset),
    .funct3 (r_funct3),
    .data   (w_aligned)
  );

  assign rsp_rdata = (rsp_valid && !r_we && rsp_fault == c_fault_ok) ? w_aligned : 32'b0;

  // Control FSM with registered response valid and fault
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= ST_IDLE;
      r_lo_buf  <= '0;
      r_funct3  <= '0;
      r_offset  <= '0;
      r_we      <= 1'b0;
      r_word    <= '0;
      rsp_valid <= 1'b0;
      rsp_fault <= c_fault_ok;
    end else begin
      case (r_state)
        ST_IDLE: begin
          rsp_valid <= 1'b0;
          if (w_accept) begin
            r_funct3  <= req_funct3;
            r_offset  <= req_addr[1:0];
            r_we      <= req_we;
            r_word    <= req_addr[ADDR_W-1:2];
            rsp_fault <= w_fault;
            if (w_issue && w_cross) begin
              r_state <= ST_SPLIT1;
            end else begin
              r_state   <= ST_RESP;
              rsp_valid <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          rsp_valid <= 1'b0;
          rsp_fault <= c_fault_ok;
          r_state   <= ST_IDLE;
        end
        ST_SPLIT1: begin
          r_lo_buf  <= mem_rdata;
          rsp_valid <= 1'b1;
          r_state   <= ST_SPLIT2;
        end
        ST_SPLIT2: begin
          rsp_valid <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: begin
          rsp_valid <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_ctrl
// Description : Self-checking bench for lsu_ctrl: directed scenarios plus
//               randomized requests against a byte-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;

  localparam int AW = 11;
  localparam int MEM_BYTES = 2048;

  logic          clk = 1'b0;
  logic          nrst;
  logic          req_valid, req_ready, req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr, req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_fault;
  logic          mem_stall;
  logic [2:0]    mem_op;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] mem_b [0:MEM_BYTES-1];
  logic [7:0] ref_b [0:MEM_BYTES-1];
  logic       mem_init_done = 1'b0;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(AW), .SPLIT_EN(1)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_fault  (rsp_fault),
    .mem_stall  (mem_stall),
    .mem_op     (mem_op),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Initial memory contents: directed words plus a fixed pattern elsewhere
  function automatic logic [7:0] init_byte(input int i);
    logic [31:0] w;
    case (i / 4)
      1:       w = 32'h8899AABB;
      64:      w = 32'h44332211;
      65:      w = 32'h88776655;
      256:     w = 32'h0000F000;
      default: w = (i / 4) * 32'h9E3779B1 + 32'h5A;
    endcase
    return w[8*(i%4) +: 8];
  endfunction

  // Data memory: 1-cycle synchronous read, sized byte writes
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < MEM_BYTES; i++) mem_b[i] <= init_byte(i);
      mem_rdata     <= 32'b0;
      mem_init_done <= 1'b1;
    end else if (!mem_stall) begin
      case (mem_op)
        3'b000: mem_b[mem_addr] <= mem_wdata[7:0];
        3'b001: begin
          mem_b[mem_addr]         <= mem_wdata[7:0];
          mem_b[mem_addr + 11'd1] <= mem_wdata[15:8];
        end
        3'b010: begin
          mem_b[mem_addr]         <= mem_wdata[7:0];
          mem_b[mem_addr + 11'd1] <= mem_wdata[15:8];
          mem_b[mem_addr + 11'd2] <= mem_wdata[23:16];
          mem_b[mem_addr + 11'd3] <= mem_wdata[31:24];
        end
        3'b100, 3'b101, 3'b110:
          mem_rdata <= {mem_b[{mem_addr[AW-1:2], 2'b11}], mem_b[{mem_addr[AW-1:2], 2'b10}],
                        mem_b[{mem_addr[AW-1:2], 2'b01}], mem_b[{mem_addr[AW-1:2], 2'b00}]};
        default: ;
      endcase
    end
  end

  // ---------------- reference model ----------------
  function automatic int sz(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [1:0] model_fault(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    longint last;
    last = longint'(addr) + sz(f3) - 1;
    if (we ? (f3 >= 3'd3) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 2'b11;
    if (last > MEM_BYTES - 1) return 2'b10;
    if (we && (int'(addr[1:0]) % sz(f3)) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] v;
    v = 32'b0;
    for (int k = 0; k < sz(f3); k++) v[8*k +: 8] = ref_b[int'(addr) + k];
    case (f3)
      3'd0:    return {{24{v[7]}}, v[7:0]};
      3'd1:    return {{16{v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  function automatic bit model_split(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    return !we && (int'(addr[1:0]) + sz(f3) > 4);
  endfunction

  // ---------------- transaction driver ----------------
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [2:0] op0, output logic [AW-1:0] a0, output logic [31:0] wd0,
                         output logic st0, output logic [AW-1:0] a1, output logic rdy_busy,
                         output int lat, output logic [31:0] rdata, output logic [1:0] fault);
    int c;
    c = 0;
    @(negedge clk);
    while (!req_ready && c < 8) begin
      @(negedge clk);
      c++;
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    #1;
    op0 = mem_op; a0 = mem_addr; wd0 = mem_wdata; st0 = mem_stall;
    a1 = '0; rdy_busy = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 6) begin
      if (!mem_stall) a1 = mem_addr;
      rdy_busy |= req_ready;
      @(posedge clk); #1;
      lat++;
    end
    rdy_busy |= req_ready;
    rdata = rsp_rdata;
    fault = rsp_fault;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); else n_pass++;
    n_total++;
    if (rsp_rdata !== 32'b0) $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); else n_pass++;
    n_total++;
    if (rsp_fault !== 2'b00) $display("FAIL reset_rsp_fault got=%b exp=00", rsp_fault); else n_pass++;
    n_total++;
    if (mem_stall !== 1'b1) $display("FAIL reset_mem_stall got=%b exp=1", mem_stall); else n_pass++;
    n_total++;
    if (mem_op !== 3'b111) $display("FAIL reset_mem_op got=%b exp=111", mem_op); else n_pass++;
    n_total++;
    if (mem_addr !== '0 || mem_wdata !== 32'b0)
      $display("FAIL reset_mem_bus got addr=%h wdata=%h exp 0/0", mem_addr, mem_wdata);
    else n_pass++;
    n_total++;
    if (req_ready !== 1'b1) $display("FAIL reset_req_ready got=%b exp=1", req_ready); else n_pass++;
    n_total++;
  endtask

  task automatic test_lw_aligned();
    logic [2:0] op0; logic [AW-1:0] a0, a1; logic [31:0] wd0, rd; logic st0, rb; int lat; logic [1:0] f;
    run_req(1'b0, 3'b010, 32'h004, 32'h0, op0, a0, wd0, st0, a1, rb, lat, rd, f);
    if (op0 !== 3'b110 || a0 !== 11'h004 || st0 !== 1'b0)
      $display("FAIL lw_issue got op=%b addr=%h stall=%b exp 110/004/0", op0, a0, st0);
    else n_pass++;
    n_total++;
    if (lat !== 1 || rd !== 32'h8899AABB || f !== 2'b00)
      $display("FAIL lw_resp got lat=%0d data=%h fault=%b exp 1/8899aabb/00", lat, rd, f);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_lb_lbu();
    logic [2:0] op0; logic [AW-1:0] a0, a1; logic [31:0] wd0, rd; logic st0, rb; int lat; logic [1:0] f;
    run_req(1'b0, 3'b000, 32'h401, 32'h0, op0, a0, wd0, st0, a1, rb, lat, rd, f);
    if (a0 !== 11'h400) $display("FAIL lb_addr got=%h exp=400", a0); else n_pass++;
    n_total++;
    if (rd !== 32'hFFFFFFF0 || f !== 2'b00) $display("FAIL lb_data got=%h fault=%b exp fffffff0/00", rd, f);
    else n_pass++;
    n_total++;
    run_req(1'b0, 3'b100, 32'h401, 32'h0, op0, a0, wd0, st0, a1, rb, lat, rd, f);
    if (rd !== 32'h000000F0 || f !== 2'b00) $display("FAIL lbu_data got=%h fault=%b exp 000000f0/00", rd, f);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_split();
    logic [2:0] op0; logic [AW-1:0] a0, a1; logic [31:0] wd0, rd; logic st0, rb; int lat; logic [1:0] f;
    run_req(1'b0, 3'b010, 32'h102, 32'h0, op0, a0, wd0, st0, a1, rb, lat, rd, f);
    if (a0 !== 11'h100 || a1 !== 11'h104)
      $display("FAIL split_addrs got first=%h second=%h exp 100/104", a0, a1);
    else n_pass++;
    n_total++;
    if (lat !== 2 || rd !== 32'h66554433 || f !== 2'b00)
      $display("FAIL split_resp got lat=%0d data=%h fault=%b exp 2/66554433/00", lat, rd, f);
    else n_pass++;
    n_total++;
    if (rb !== 1'b0) $display("FAIL split_ready_busy got=%b exp=0", rb); else n_pass++;
    n_total++;
  endtask

  task automatic test_store();
    logic [2:0] op0; logic [AW-1:0] a0, a1; logic [31:0] wd0, rd; logic st0, rb; int lat; logic [1:0] f;
    run_req(1'b1, 3'b001, 32'h00A, 32'h1234BEEF, op0, a0, wd0, st0, a1, rb, lat, rd, f);
    ref_b[10] = 8'hEF; ref_b[11] = 8'hBE;
    if (op0 !== 3'b001 || a0 !== 11'h00A || wd0 !== 32'h1234BEEF || st0 !== 1'b0)
      $display("FAIL sh_issue got op=%b addr=%h wdata=%h stall=%b exp 001/00a/1234beef/0", op0, a0, wd0, st0);
    else n_pass++;
    n_total++;
    if (lat !== 1 || f !== 2'b00 || rd !== 32'b0)
      $display("FAIL sh_resp got lat=%0d fault=%b data=%h exp 1/00/0", lat, f, rd);
    else n_pass++;
    n_total++;
    run_req(1'b0, 3'b101, 32'h00A, 32'h0, op0, a0, wd0, st0, a1, rb, lat, rd, f);
    if (rd !== 32'h0000BEEF) $display("FAIL sh_readback got=%h exp=0000beef", rd); else n_pass++;
    n_total++;
    run_req(1'b1, 3'b010, 32'h00A, 32'hDEADDEAD, op0, a0, wd0, st0, a1, rb, lat, rd, f);
    if (f !== 2'b01 || st0 !== 1'b1 || lat !== 1)
      $display("FAIL sw_misaligned got fault=%b stall=%b lat=%0d exp 01/1/1", f, st0, lat);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_faults();
    logic [2:0] op0; logic [AW-1:0] a0, a1; logic [31:0] wd0, rd; logic st0, rb; int lat; logic [1:0] f;
    logic [31:0] addrs [3];
    logic [2:0]  f3s   [3];
    logic [1:0]  exps  [3];
    addrs = '{32'h7FE, 32'h010, 32'h7FE};
    f3s   = '{3'b010, 3'b011, 3'b011};
    exps  = '{2'b10, 2'b11, 2'b11};
    for (int i = 0; i < 3; i++) begin
      run_req(1'b0, f3s[i], addrs[i], 32'h0, op0, a0, wd0, st0, a1, rb, lat, rd, f);
      if (f !== exps[i] || st0 !== 1'b1 || lat !== 1 || rd !== 32'b0)
        $display("FAIL fault_case%0d got fault=%b stall=%b lat=%0d data=%h exp %b/1/1/0",
                 i, f, st0, lat, rd, exps[i]);
      else n_pass++;
      n_total++;
    end
  endtask

  task automatic test_reset_mid();
    int c;
    c = 0;
    @(negedge clk);
    while (!req_ready && c < 8) begin
      @(negedge clk);
      c++;
    end
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h102; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (mem_stall !== 1'b0 || mem_addr !== 11'h104)
      $display("FAIL midrst_in_split1 got stall=%b addr=%h exp 0/104", mem_stall, mem_addr);
    else n_pass++;
    n_total++;
    nrst = 1'b0;
    #1;
    if (mem_stall !== 1'b1 || rsp_valid !== 1'b0 || mem_op !== 3'b111)
      $display("FAIL midrst_immediate got stall=%b rsp_valid=%b op=%b exp 1/0/111", mem_stall, rsp_valid, mem_op);
    else n_pass++;
    n_total++;
    @(negedge clk);
    nrst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
        $display("FAIL midrst_after cycle%0d got rsp_valid=%b req_ready=%b exp 0/1", k, rsp_valid, req_ready);
      else n_pass++;
      n_total++;
    end
  endtask

  task automatic test_random();
    logic [2:0] op0; logic [AW-1:0] a0, a1; logic [31:0] wd0, rd; logic st0, rb; int lat; logic [1:0] f;
    logic we; logic [2:0] f3; logic [31:0] addr, wd;
    logic [1:0] ef; logic [31:0] ed; int el;
    for (int it = 0; it < 150; it++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0:       addr = $urandom;
        1:       addr = 32'($urandom_range(2040, 2047));
        default: addr = 32'($urandom_range(0, 2047));
      endcase
      wd = $urandom;
      ef = model_fault(we, f3, addr);
      ed = (ef == 2'b00 && !we) ? model_load(f3, addr) : 32'b0;
      el = (ef == 2'b00 && model_split(we, f3, addr)) ? 2 : 1;
      run_req(we, f3, addr, wd, op0, a0, wd0, st0, a1, rb, lat, rd, f);
      if (ef == 2'b00 && we)
        for (int k = 0; k < sz(f3); k++) ref_b[int'(addr) + k] = wd[8*k +: 8];
      if (f !== ef)
        $display("FAIL rand%0d_fault we=%b f3=%b addr=%h got=%b exp=%b", it, we, f3, addr, f, ef);
      else n_pass++;
      n_total++;
      if (rd !== ed)
        $display("FAIL rand%0d_data we=%b f3=%b addr=%h got=%h exp=%h", it, we, f3, addr, rd, ed);
      else n_pass++;
      n_total++;
      if (lat !== el)
        $display("FAIL rand%0d_latency addr=%h got=%0d exp=%0d", it, addr, lat, el);
      else n_pass++;
      n_total++;
      if (st0 !== (ef != 2'b00))
        $display("FAIL rand%0d_issue_stall got=%b exp=%b", it, st0, (ef != 2'b00));
      else n_pass++;
      n_total++;
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) ref_b[i] = init_byte(i);
    nrst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = 32'b0; req_wdata = 32'b0;
    repeat (3) @(negedge clk);
    test_reset();
    nrst = 1'b1;
    test_lw_aligned();
    test_lb_lbu();
    test_split();
    test_store();
    test_faults();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store initiator in the MEM stage of the RISC-V pipeline.
- Accepts one load/store request at a time from the core over a valid/ready handshake.
- Drives the data-memory wrapper port (op_code, rwaddr, wdata, stall); that memory has 1-cycle synchronous read latency and banks on address bit 10.
- Does all load extraction and sign/zero extension itself, splits misaligned loads into two aligned word reads, and faults illegal, out-of-range and misaligned-store requests.

Parameters:
- ADDR_W, 11: memory byte-address width; legal range is 0 to 2^ADDR_W-1.
- SPLIT_EN, 1: 1 = misaligned loads are split into two reads; 0 = misaligned loads fault as misaligned.

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid & req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and faults.
- rsp_fault  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal funct3.
- mem_stall  out  1  1 = memory idle (both banks' chip enables held off).
- mem_op  out  3  memory op_code.
- mem_addr  out  ADDR_W  memory rwaddr.
- mem_wdata  out  32  memory wdata.
- mem_rdata  in  32  memory rdata, valid the cycle after a read issue.

Behaviour:
- Memory op encoding; op[2]=0 means write:
  - StoreByte 000, StoreHalfWord 001, StoreWord 010.
  - LoadByte 100, LoadHalfWord 101, LoadWord 110.
  - Idle 111.
- Reset (async, nrst low), including mid-operation:
  - state = IDLE, lo_buf = 0, rsp_valid = 0, rsp_rdata = 0, rsp_fault = 00.
  - mem_stall = 1, mem_op = Idle, mem_addr = 0, mem_wdata = 0.
  - Any in-flight request is dropped with no response.
- States:
  - IDLE: req_ready = 1.
  - RESP: one-cycle response, for aligned loads, stores and faults.
  - SPLIT1 / SPLIT2: misaligned load, first and second word.
- Fault check at acceptance, combinational. Priority: illegal > range > misaligned.
  - Illegal: load funct3 in {011, 110, 111}, or store funct3 >= 011.
  - Range: req_addr + size - 1 > 2^ADDR_W - 1, or any req_addr[31:ADDR_W] bit set.
  - Misaligned: store with a size-misaligned address; or load when SPLIT_EN = 0.
  - On fault: no memory access (mem_stall stays 1); go to RESP; rsp_fault is set the next cycle.
- Issue (same cycle as acceptance, combinational from the request; mem_stall = 0):
  - Store: mem_op = sized store, mem_addr = req_addr[ADDR_W-1:0], mem_wdata = req_wdata, then go to RESP.
  - Load: mem_op = LoadWord, mem_addr = {req_addr[ADDR_W-1:2], 2'b00}.
    - Aligned load: go to RESP.
    - Misaligned load (LH at offset 3; LW at offset 1/2/3): go to SPLIT1.
  - Registers captured at acceptance: funct3, offset, we.
- RESP:
  - rsp_valid = 1; rsp_rdata = extract(mem_rdata) for loads.
  - Return to IDLE; mem_stall = 1.
- SPLIT1:
  - lo_buf <= mem_rdata.
  - Issue LoadWord at word address + 4; go to SPLIT2.
- SPLIT2:
  - Form window {mem_rdata, lo_buf}, shift right by offset*8, extract.
  - rsp_valid = 1; go to IDLE.
- Extract rules:
  - LB/LH: sign-extend from bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: pass through.
- Latency: aligned access or fault = response 1 cycle after acceptance; split load = 2 cycles.
- Throughput: req_ready is low in every non-IDLE state, so no overlap between requests.
- mem_stall = 1 in every cycle without an issue; memory-facing signals hold Idle values then.

Decomposition:
- Shared constants in mem.vh, beside the existing memory op macros:
  - memory op codes, funct3 codes, fault codes, FSM state encodings.
- One combinational sub-module, lsu_load_align:
  - inputs: 64-bit window, offset, funct3; output: 32-bit extended data.
  - used in both RESP and SPLIT2.

Test Plan:
- LW addr 0x004, mem word 0x8899AABB:
  - mem_op = 110 and mem_addr = 0x004 in the accept cycle.
  - Next cycle: rsp_valid = 1, rsp_rdata = 0x8899AABB, fault 00.
- LB vs LBU addr 0x401, mem word at 0x400 = 0x0000F000:
  - mem_addr = 0x400 (bank 2).
  - LB → 0xFFFFFFF0; LBU → 0x000000F0.
- LW addr 0x102, words 0x100 = 0x44332211, 0x104 = 0x88776655:
  - Reads at 0x100 then 0x104.
  - rsp_valid 2 cycles after accept with rsp_rdata = 0x66554433; req_ready low for 2 cycles.
- SH addr 0x00A, req_wdata 0x1234BEEF:
  - mem_op = 001, mem_addr = 0x00A, mem_wdata = 0x1234BEEF; response next cycle, fault 00.
  - SW addr 0x00A → fault 01, mem_stall held 1.
- Fault cases, each with mem_stall held 1 and rsp_valid the next cycle:
  - LW addr 0x7FE → fault 10.
  - Load funct3 011 → fault 11.
  - Load funct3 011 at addr 0x7FE → fault 11 (priority).
- Reset mid-operation: nrst low during SPLIT1.
  - Immediately: mem_stall = 1, rsp_valid = 0.
  - After release: state IDLE, req_ready = 1, no stale response.
